// File: rtl/fb_pkg.sv
// Shared types and frame-size helpers for the framebuffer pixel fetch path.
package fb_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } fetch_state_t;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// First-word-fall-through pixel FIFO with synchronous flush; head reads 0 when empty.
module fb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  pixel_t                   wdata_i,
  output pixel_t                   rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  pixel_t        mem_q [DEPTH];
  logic          do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & valid_o & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked by valid_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/fb_pixel_fetch.sv
// Credit-based framebuffer reader feeding the VGA stage through a small FWFT FIFO.
module fb_pixel_fetch
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 2,
  parameter int DEPTH    = 16
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [23:0]       pix_rgb,
  output logic              pix_valid,
  output logic              underflow,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(frame_pixels(H_ACTIVE, V_ACTIVE) - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic              underflow_q, underflow_d;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       credit_used;
  logic              issue, push, pop;
  pixel_t            head;

  // Occupied plus in-flight slots; a read may only issue while a slot is free.
  always_comb begin
    credit_used = {1'b0, fifo_cnt};
    for (int i = 0; i < RD_LAT; i++) credit_used = credit_used + (CW+1)'(tag_q[i]);
  end

  assign issue = rst & ~frame_start & (state_q == FETCH) & (credit_used < (CW+1)'(DEPTH));
  assign push  = tag_q[RD_LAT-1] & ~frame_start;
  assign pop   = pix_rd & pix_valid & ~frame_start;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tag_d       = (tag_q << 1) | RD_LAT'(issue);
    underflow_d = underflow_q | (pix_rd & ~pix_valid);
    if (frame_start) begin
      state_d     = FETCH;
      addr_d      = '0;
      tag_d       = '0;
      underflow_d = 1'b0;
    end else if (issue) begin
      if (addr_q == LAST_ADDR) state_d = DONE;
      else                     addr_d  = addr_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      addr_q      <= '0;
      tag_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      underflow_q <= underflow_d;
    end
  end

  fb_pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (rst),
    .flush_i (frame_start),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pixel_t'(mem_rdata)),
    .rdata_o (head),
    .valid_o (pix_valid),
    .count_o (fifo_cnt)
  );

  assign pix_rgb   = head;
  assign mem_rd    = issue;
  assign mem_addr  = addr_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Directed scoreboard bench: full-size frame fetch plus a shrunk 4x2 frame instance.
module tb_fb_pixel_fetch;
  import fb_pkg::*;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        rst, fs, rd, pv, uf, mrd;
  logic [23:0] rgb, mrdata;
  logic [18:0] maddr, a1, a2;

  logic        rst2, fs2, rd2, pv2, uf2, mrd2;
  logic [23:0] rgb2, mrdata2;
  logic [2:0]  maddr2, b1, b2;

  fb_pixel_fetch #(.H_ACTIVE(640), .V_ACTIVE(480), .ADDR_W(19), .RD_LAT(2), .DEPTH(16)) u_big (
    .CLOCK_50(CLOCK_50), .rst(rst), .frame_start(fs), .pix_rd(rd), .pix_rgb(rgb),
    .pix_valid(pv), .underflow(uf), .mem_rd(mrd), .mem_addr(maddr), .mem_rdata(mrdata));

  fb_pixel_fetch #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(3), .RD_LAT(2), .DEPTH(16)) u_sml (
    .CLOCK_50(CLOCK_50), .rst(rst2), .frame_start(fs2), .pix_rd(rd2), .pix_rgb(rgb2),
    .pix_valid(pv2), .underflow(uf2), .mem_rd(mrd2), .mem_addr(maddr2), .mem_rdata(mrdata2));

  // Memory model: data = address, returned two cycles after the strobe.
  always @(posedge CLOCK_50) begin
    a1 <= maddr;  a2 <= a1;
    b1 <= maddr2; b2 <= b1;
  end
  assign mrdata  = {5'd0, a2};
  assign mrdata2 = {21'd0, b2};

  int total = 0;
  int bad   = 0;
  int exp_pix[$];
  int exp_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  always @(negedge CLOCK_50) begin
    if (rst === 1'b1) begin
      total++;
      assert (u_big.fifo_cnt <= 5'd16) else begin
        bad++;
        $error("FAIL fifo_cnt observed=%0d expected<=16", u_big.fifo_cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd, npix, c;
    bit hit;
    rst = 0; fs = 0; rd = 0;
    rst2 = 0; fs2 = 0; rd2 = 0;
    repeat (3) tick();
    chk("rst_mrd", mrd, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_pv", pv, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_uf", uf, 0);

    // Fill from reset with no consumer: 16 reads, then credit stalls.
    for (int i = 0; i < 16; i++) exp_addr.push_back(i);
    nrd = 0;
    rst = 1;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) tick(); else #1;
      if (mrd) begin
        nrd++;
        if (exp_addr.size() > 0) chk("fill_addr", maddr, exp_addr.pop_front());
      end
      if (k == 2) chk("fill_pv_c2", pv, 0);
      if (k == 3) begin
        chk("fill_pv_c3", pv, 1);
        chk("fill_rgb_c3", rgb, 0);
      end
    end
    chk("fill_nrd", nrd, 16);
    chk("fill_mrd_stall", mrd, 0);

    // Continuous drain until address 100 is about to issue.
    for (int i = 0; i < 400; i++) exp_pix.push_back(i);
    rd = 1;
    hit = 0;
    for (int r = 0; r < 200; r++) begin
      if (r > 0) tick(); else #1;
      if (r >= 1) begin
        chk("drain_mrd", mrd, 1);
        if (maddr == 19'd100) begin
          hit = 1;
          break;
        end
        chk("drain_addr", maddr, 15 + r);
      end
      chk("drain_pv", pv, 1);
      chk("drain_rgb", rgb, exp_pix.pop_front());
    end
    chk("drain_hit100", hit, 1);
    chk("drain_uf", uf, 0);

    // Mid-frame restart with words 98/99 still in flight.
    fs = 1; rd = 0;
    #1 chk("fs_mrd", mrd, 0);
    tick();
    fs = 0;
    #1;
    chk("fs_pv", pv, 0);
    chk("fs_rgb", rgb, 0);
    chk("fs_mrd_restart", mrd, 1);
    chk("fs_addr", maddr, 0);
    chk("fs_uf", uf, 0);
    exp_pix.delete();
    for (int i = 0; i < 32; i++) exp_pix.push_back(i);
    for (c = 0; c < 10; c++) begin
      if (c > 0) tick();
      if (pv) break;
    end
    chk("restart_lat", c, 3);
    chk("restart_rgb", rgb, exp_pix.pop_front());

    // frame_start together with pix_rd while 5 entries are queued.
    repeat (4) tick();
    fs = 1; rd = 1;
    #1 chk("fsrd_mrd", mrd, 0);
    tick();
    fs = 0; rd = 0;
    #1;
    chk("fsrd_pv", pv, 0);
    chk("fsrd_uf", uf, 0);
    chk("fsrd_mrd", mrd, 1);
    chk("fsrd_addr", maddr, 0);
    exp_pix.delete();
    for (int i = 0; i < 64; i++) exp_pix.push_back(i);
    npix = 0;
    for (int k = 0; k < 40; k++) begin
      if (pv) begin
        chk("fsrd_rgb", rgb, exp_pix.pop_front());
        npix++;
        rd = 1;
      end else rd = 0;
      tick();
    end
    rd = 0;
    chk("fsrd_npix", npix, 37);
    chk("fsrd_uf_end", uf, 0);

    // Shrunk 4x2 frame: underflow right after reset, then a full drained frame.
    chk("sml_rst_mrd", mrd2, 0);
    chk("sml_rst_pv", pv2, 0);
    rst2 = 1; rd2 = 1;
    #1;
    chk("sml_c0_mrd", mrd2, 1);
    chk("sml_c0_addr", maddr2, 0);
    exp_addr.delete();
    for (int i = 1; i < 8; i++) exp_addr.push_back(i);
    exp_pix.delete();
    for (int i = 0; i < 8; i++) exp_pix.push_back(i);
    nrd = 1; npix = 0;
    tick();
    rd2 = 0;
    chk("sml_uf_set", uf2, 1);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      if (mrd2) begin
        nrd++;
        if (exp_addr.size() > 0) chk("sml_addr", maddr2, exp_addr.pop_front());
      end
      if (pv2) begin
        if (exp_pix.size() > 0) chk("sml_rgb", rgb2, exp_pix.pop_front());
        npix++;
        rd2 = 1;
      end else rd2 = 0;
    end
    tick();
    rd2 = 0;
    chk("sml_nrd", nrd, 8);
    chk("sml_npix", npix, 8);
    chk("sml_pv_end", pv2, 0);
    chk("sml_mrd_end", mrd2, 0);
    chk("sml_state", u_sml.state_q, DONE);
    chk("sml_uf_held", uf2, 1);
    fs2 = 1;
    #1;
    chk("sml_fs_uf", uf2, 1);
    chk("sml_fs_mrd", mrd2, 0);
    tick();
    fs2 = 0;
    #1;
    chk("sml_uf_clr", uf2, 0);
    chk("sml_re_mrd", mrd2, 1);
    chk("sml_re_addr", maddr2, 0);
    chk("sml_re_state", u_sml.state_q, FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_pixel_fetch.md
Name: fb_pixel_fetch

Overview:
- Upstream feeder for the VGA timing/output stage.
- Streams a frame of 24-bit RGB pixels from the framebuffer memory read port into a small first-word-fall-through (FWFT) FIFO.
- The VGA stage pops one pixel per active-video pixel clock and pulses frame_start once per frame to restart the fetch at address 0.
- Read issue is credit-based, so the FIFO never overflows; underflow is flagged and held.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- ADDR_W, 19, framebuffer word-address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- RD_LAT, 2, fixed memory read latency in cycles, >= 1
- DEPTH, 16, pixel FIFO depth, power of 2, >= RD_LAT+1

Ports:
- CLOCK_50  in  1  sole clock; all logic on its rising edge
- rst  in  1  reset, asynchronous assert, active-low
- frame_start  in  1  single-cycle pulse from the VGA stage at start of vertical blanking
- pix_rd  in  1  VGA stage consumes the head pixel this cycle
- pix_rgb  out  24  head pixel {R[23:16],G[15:8],B[7:0]}; 0 when the FIFO is empty
- pix_valid  out  1  FIFO non-empty
- underflow  out  1  sticky: pix_rd was seen while the FIFO was empty
- mem_rd  out  1  read strobe, one word per cycle
- mem_addr  out  ADDR_W  read address, linear row-major
- mem_rdata  in  24  read data, valid exactly RD_LAT cycles after its mem_rd

Behaviour:
- Reset (rst low) sets all outputs to 0: mem_rd=0, mem_addr=0, pix_valid=0, pix_rgb=0, underflow=0.
  - State becomes FETCH, address counter 0, FIFO empty, in-flight tag pipe cleared.
- Clocking: one clock, CLOCK_50, rising edge; reset asynchronous, active-low, on port rst.
- State machine has two states, FETCH and DONE.
  - FETCH: assert mem_rd whenever fifo_count + inflight < DEPTH. inflight is the number of set bits in an RD_LAT-deep tag shift register.
  - On each issued read, the address increments.
  - After issuing address H_ACTIVE*V_ACTIVE-1, go to DONE. mem_rd stays 0 and the address holds.
  - DONE to FETCH only on frame_start.
- First mem_rd occurs in the first cycle after rst deasserts, and in the cycle after a frame_start.
- Return path: the tag for a read issued at cycle t emerges at t+RD_LAT.
  - mem_rdata is written to the FIFO on that edge.
  - pix_valid rises at t+RD_LAT+1.
- FIFO is FWFT: pix_rgb is the head word whenever pix_valid=1.
  - pix_rd with pix_valid=1 pops; the next word (or 0) appears the following cycle.
  - Simultaneous push and pop leaves the count unchanged.
- pix_rd with pix_valid=0 sets underflow and pops nothing. underflow holds until frame_start or reset.
- frame_start, in any state, causes all of the following:
  - FIFO is flushed.
  - Tag pipe is cleared, so the returning in-flight data is discarded and never written.
  - Address is set to 0, state goes to FETCH, underflow is cleared.
  - mem_rd is 0 in the frame_start cycle.
- Simultaneous events:
  - frame_start with pix_rd: the flush wins and the pop is ignored.
  - frame_start on the same cycle as a data return: the data is dropped.
- Full: the credit rule guarantees no push while full. A bench assertion checks fifo_count <= DEPTH.
- Count and address widths: fifo_count is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

Decomposition:
- fb_pkg holds:
  - pixel_t: packed struct of r, g, b, each logic [7:0]
  - fetch_state_t: enum FETCH, DONE
  - localparam FRAME_PIXELS = H_ACTIVE*V_ACTIVE
- One sub-module, fb_pixel_fifo: parameterised DEPTH, FWFT, synchronous flush input, count output.
- Credit logic, tag pipe and address FSM live in fb_pixel_fetch.

Test Plan:
- Reset release, memory model returning data = address, RD_LAT=2, pix_rd=0:
  - first mem_rd with addr 0 the cycle after release; exactly 16 reads issued, then mem_rd=0.
  - pix_valid rises 3 cycles after the first read; pix_rgb=24'h000000.
- Continuous pix_rd after the FIFO fills: pix_rgb sequence 0,1,2,... with no gaps; mem_rd sustains 1 per cycle; underflow stays 0.
- Shrunk frame H_ACTIVE=4, V_ACTIVE=2, drained continuously:
  - exactly 8 reads, addresses 0..7, state DONE, mem_rd=0.
  - 8 pixels delivered, then pix_valid=0.
- pix_rd asserted while empty (the cycle after reset) -> underflow=1, held through a full frame; cleared the cycle after frame_start.
- frame_start issued mid-frame at addr 100 with 2 reads in flight:
  - next cycle pix_valid=0.
  - in-flight words 98 and 99 are never presented.
  - the first pixel after restart is 0.
- frame_start and pix_rd in the same cycle with 5 entries queued -> FIFO empty next cycle, no underflow set, fetch restarts at addr 0.
